// File: rtl/scs8hd_a211o_pipe.sv
// Pipelined per-lane a211o / a211oi gate with a DEPTH-stage elastic valid/ready pipeline.
// Power pins are ports only under SC_USE_PG_PIN; otherwise they are tied internally.
module scs8hd_a211o_pipe #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 2,
    parameter bit INVERT = 1'b0
) (
`ifdef SC_USE_PG_PIN
    input  logic             vpwr,
    input  logic             vgnd,
    input  logic             vpb,
    input  logic             vnb,
`endif
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] C1,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] X,
    output logic [2:0]       OCC
);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply1 vpb;
    supply0 vgnd;
    supply0 vnb;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; ready never depends on valid of the same side, and a producer
    // holds its payload steady until the transfer completes.

    logic             pwr_ok;
    logic [WIDTH-1:0] res;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] data  [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [2:0]       occ_sum;

    assign pwr_ok = vpwr & vpb & ~vgnd & ~vnb;

    always_comb begin
        res = (A1 & A2) | B1 | C1;
        if (INVERT) begin
            res = ~res;
        end
    end

    // Stage k may move when any stage from k to the output is empty, or the
    // output is being drained; this is the unrolled form of the ripple rule.
    always_comb begin
        logic full_tail;
        adv       = '0;
        full_tail = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            full_tail = full_tail & v[k];
            adv[k]    = OUT_READY | ~full_tail;
        end
    end

    always_comb begin
        src_v    = '0;
        src_v[0] = IN_VALID & pwr_ok;
        src_d[0] = res;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v[k-1];
            src_d[k] = data[k-1];
        end
    end

    // Data registers only load when a valid item arrives, so bubbles never
    // disturb held data.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v[k] <= src_v[k];
                    if (src_v[k]) begin
                        data[k] <= src_d[k];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_sum = occ_sum + 3'(v[k]);
        end
    end

    assign IN_READY  = adv[0] & pwr_ok;
    assign OUT_VALID = v[DEPTH-1];
    assign X         = data[DEPTH-1];
    assign OCC       = occ_sum;

endmodule

// File: doc/scs8hd_a211o_pipe.md
SCS8HD_A211O_PIPE -- requirements
Module: scs8hd_a211o_pipe

Interface
REQ-001 Parameter WIDTH, default 4, number of independent bit lanes (legal 1..32).
REQ-002 Parameter DEPTH, default 2, number of register stages (legal 1..4).
REQ-003 Parameter INVERT, default 0, function select: 0 = a211o X=(A1&A2)|B1|C1; 1 = a211oi X=~((A1&A2)|B1|C1).
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 RESETB  input  1  reset, asynchronous assert, active-low; releases on the CLK edge after deassertion.
REQ-006 IN_VALID  input  1  upstream presents a valid operand set.
REQ-007 IN_READY  output  1  block accepts the operand set this cycle.
REQ-008 A1, A2, B1, C1  input  WIDTH each  per-lane operands.
REQ-009 OUT_VALID  output  1  X holds a valid result.
REQ-010 OUT_READY  input  1  downstream consumes X this cycle.
REQ-011 X  output  WIDTH  registered per-lane result.
REQ-012 OCC  output  3  count of occupied stages, 0..DEPTH.
REQ-013 vpwr, vgnd, vpb, vnb  input  1 each  present only under SC_USE_PG_PIN; otherwise vpwr, vpb tied supply1 and vgnd, vnb tied supply0 internally.

Function
REQ-014 Lane i result = INVERT ? ~((A1[i]&A2[i])|B1[i]|C1[i]) : ((A1[i]&A2[i])|B1[i]|C1[i]); lanes do not interact.
REQ-015 Result is computed combinationally at input and captured into stage 0 on handshake (IN_VALID & IN_READY).
REQ-016 Each stage k holds a valid bit V[k] and WIDTH data bits; X = data of stage DEPTH-1; OUT_VALID = V[DEPTH-1].
REQ-017 Stage k advances (accepts from k-1 or from input when k=0) when ~V[k] or stage k+1 advances; last stage advances when ~V[DEPTH-1] or OUT_READY.
REQ-018 IN_READY = advance condition of stage 0; IN_READY is independent of IN_VALID (no combinational loop on IN_VALID).
REQ-019 Bubbles collapse: an empty stage accepts even while downstream is stalled.
REQ-020 Latency with no stall: operand captured at edge n appears on X with OUT_VALID=1 after edge n+DEPTH-1 (DEPTH=1: visible right after capture edge).
REQ-021 Throughput: one result per cycle while OUT_READY=1 continuously.
REQ-022 A stage whose valid bit is 0 and does not accept holds data unchanged; data changes only on accept.
REQ-023 X and OUT_VALID hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 Full condition: all V=1 and OUT_READY=0 -> IN_READY=0, no state change.
REQ-025 Simultaneous accept and emit in one cycle keeps OCC unchanged; OCC = sum of V bits, updated same edge.
REQ-026 OUT_READY asserted with OUT_VALID=0 has no effect.
REQ-027 X/Z on operands propagate per gate semantics; control X on IN_VALID or OUT_READY is not required to be handled.

Reset
REQ-028 RESETB=0 immediately clears all V bits, all data registers to 0, OUT_VALID=0, X=0 (independent of INVERT), OCC=0.
REQ-029 IN_READY=1 during and after reset (all stages empty).
REQ-030 Reset mid-operation discards all in-flight results; no partial output emitted after release.
REQ-031 First capture possible on first rising CLK edge with RESETB=1.

Verification
REQ-032 WIDTH=4, DEPTH=2, INVERT=0, OUT_READY=1: A1=4'b1010, A2=4'b1100, B1=4'b0001, C1=4'b0000 accepted at edge 1 -> X=4'b1001, OUT_VALID=1 after edge 2.
REQ-033 Same operands, INVERT=1 -> X=4'b0110 after edge 2.
REQ-034 DEPTH=3, OUT_READY=0, IN_VALID=1 continuously: 3 accepts, then IN_READY=0, OCC=3; raise OUT_READY for one cycle -> one emit plus one accept, OCC stays 3.
REQ-035 DEPTH=4, back-to-back 8 inputs with OUT_READY=1 -> 8 results in order, one per cycle, first after 3 edges.
REQ-036 Assert RESETB=0 asynchronously between edges with OCC=2 -> OUT_VALID=0, X=0, OCC=0 before next edge; no stale result after release.
REQ-037 OUT_READY toggled pseudo-randomly with DEPTH=2: scoreboard confirms no drop, duplicate or reorder, and X stable during stall.
